// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse stretcher.
//   - FSM state encoding (IDLE/HIGH/GAP) as 2-bit constants plus enum type
//   - width helpers for sizing the phase counter
package pulse_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_HIGH = ST_HIGH,
    S_GAP  = ST_GAP
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // $clog2 with a floor of one bit, so a counter that only ever holds 0
  // still has a legal declaration.
  function automatic int clog2_min1(input int v);
    return ($clog2(v) < 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// Saturating up/down counter used as the strobe queue depth.
// Ports:
//   clk, rst   clock, async active-high reset
//   inc, dec   count up / down requests (both together: no change)
//   count      current value, 0..MAX
//   full       count == MAX
//   drop       inc refused because full and no simultaneous dec
module sat_updown_counter #(
  parameter int MAX = 3,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         drop
);

  localparam logic [W-1:0] MAXV = W'(MAX);

  logic [W-1:0] count_q, count_d;

  assign full  = (count_q == MAXV);
  assign drop  = inc & ~dec & full;
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (inc && !dec && !full)
      count_d = count_q + W'(1);
    else if (dec && !inc && (count_q != '0))
      count_d = count_q - W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle strobes into fixed-width output pulses with a
// guaranteed low gap between them; strobes arriving while busy are queued.
// Ports:
//   clk, rst    clock, async active-high reset
//   pulse_in    strobe, one request per sampled-high cycle
//   clr_ovf     synchronous clear of ovf (a same-cycle drop wins)
//   out         stretched pulse (decoded from registered state)
//   busy        high while in HIGH or GAP
//   pending     number of queued requests
//   ovf         sticky: a request was dropped because the queue was full
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_MAX    = 3,
  parameter int PEND_W      = $clog2(PEND_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  input  logic              clr_ovf,
  output logic              out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              ovf
);

  localparam int CW = clog2_min1(max2(HIGH_CYCLES, GAP_CYCLES));
  localparam logic [CW-1:0] HIGH_LAST = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic gap_end, pend_zero, pend_inc, pend_dec;
  logic pend_full, pend_drop;
  logic [PEND_W-1:0] pend_cnt;

  assign out       = (state_q == ST_HIGH);
  assign busy      = (state_q != ST_IDLE);
  assign pending   = pend_cnt;
  assign ovf       = ovf_q;

  assign gap_end   = (state_q == ST_GAP) && (cnt_q == GAP_LAST);
  assign pend_zero = (pend_cnt == '0);
  // A strobe landing on the last gap cycle with an empty queue starts the
  // next pulse directly instead of being queued.
  assign pend_inc  = busy & pulse_in & ~(gap_end & pend_zero);
  assign pend_dec  = gap_end & ~pend_zero;

  sat_updown_counter #(
    .MAX (PEND_MAX),
    .W   (PEND_W)
  ) u_pend (
    .clk   (clk),
    .rst   (rst),
    .inc   (pend_inc),
    .dec   (pend_dec),
    .count (pend_cnt),
    .full  (pend_full),
    .drop  (pend_drop)
  );

  // Next-state and phase counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pulse_in) state_d = ST_HIGH;
      end
      ST_HIGH: begin
        if (cnt_q == HIGH_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_GAP: begin
        if (gap_end) begin
          cnt_d   = '0;
          state_d = (!pend_zero || pulse_in) ? ST_HIGH : ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Sticky overflow; a drop in the same cycle as clr_ovf keeps it set.
  always_comb begin
    ovf_d = ovf_q;
    if (pend_drop && pend_full) ovf_d = 1'b1;
    else if (clr_ovf)           ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
module tb_pulse_stretcher;

  localparam int H  = 4;
  localparam int G  = 2;
  localparam int PM = 3;
  localparam int PW = $clog2(PM + 1);

  logic clk = 0, rst = 1, pulse_in = 0, clr_ovf = 0;
  logic out, busy, ovf;
  logic [PW-1:0] pending;

  pulse_stretcher #(.HIGH_CYCLES(H), .GAP_CYCLES(G), .PEND_MAX(PM)) dut (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .clr_ovf(clr_ovf),
    .out(out), .busy(busy), .pending(pending), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: tracks the start edge of the current pulse and a
  // queue depth; outputs follow from the start edge by arithmetic.
  longint t = 0, s = 0;
  bit     sv = 0, movf = 0;
  int     pend = 0;

  task automatic model_reset();
    sv = 0; pend = 0; movf = 0;
  endtask

  task automatic model_step(input bit p, input bit c);
    bit drop;
    drop = 0;
    t++;
    if (sv && t <= s + H + G) begin
      if (t == s + H + G) begin
        if (pend > 0) begin s = t; if (!p) pend--; end
        else if (p) s = t;
        else sv = 0;
      end else if (p) begin
        if (pend == PM) drop = 1; else pend++;
      end
    end else if (p) begin
      s = t; sv = 1;
    end
    if (drop) movf = 1; else if (c) movf = 0;
  endtask

  function automatic int m_out();  return int'(sv && t >= s && t <= s + H - 1); endfunction
  function automatic int m_busy(); return int'(sv && t <= s + H + G - 1); endfunction

  // Called at a negedge: drive, take one rising edge, come back to negedge.
  task automatic tick(input bit p, input bit c);
    pulse_in = p; clr_ovf = c;
    @(posedge clk);
    model_step(p, c);
    @(negedge clk);
    pulse_in = 0; clr_ovf = 0;
  endtask

  task automatic do_reset();
    rst = 1; model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  typedef struct {
    bit p;
    bit o;
    bit b;
    int pn;
    bit ov;
  } vec_t;

  vec_t vt[19];
  int   starts[$];
  bit   prev_out;

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_out", out, 0); chk("rst_busy", busy, 0);
    chk("rst_pend", pending, 0); chk("rst_ovf", ovf, 0);

    // Three strobes back to back; queued pulses every H+G cycles.
    vt[0]  = '{1,1,1,0,0}; vt[1]  = '{1,1,1,1,0}; vt[2]  = '{1,1,1,2,0};
    vt[3]  = '{0,1,1,2,0}; vt[4]  = '{0,0,1,2,0}; vt[5]  = '{0,0,1,2,0};
    vt[6]  = '{0,1,1,1,0}; vt[7]  = '{0,1,1,1,0}; vt[8]  = '{0,1,1,1,0};
    vt[9]  = '{0,1,1,1,0}; vt[10] = '{0,0,1,1,0}; vt[11] = '{0,0,1,1,0};
    vt[12] = '{0,1,1,0,0}; vt[13] = '{0,1,1,0,0}; vt[14] = '{0,1,1,0,0};
    vt[15] = '{0,1,1,0,0}; vt[16] = '{0,0,1,0,0}; vt[17] = '{0,0,1,0,0};
    vt[18] = '{0,0,0,0,0};
    for (int i = 0; i < 19; i++) begin
      tick(vt[i].p, 1'b0);
      chk($sformatf("tab%0d_out", i), out, vt[i].o);
      chk($sformatf("tab%0d_busy", i), busy, vt[i].b);
      chk($sformatf("tab%0d_pend", i), pending, vt[i].pn);
      chk($sformatf("tab%0d_ovf", i), ovf, vt[i].ov);
    end

    // Held high for 5 cycles: queue fills, 5th strobe dropped with clr_ovf
    // asserted the same cycle (set wins); exactly 4 pulses result.
    repeat (3) tick(0, 0);
    prev_out = 0;
    for (int i = 0; i < 45; i++) begin
      if (i < 5) tick(1, i == 4);
      else       tick(0, 0);
      if (i == 3) chk("hold_pend3", pending, 3);
      if (i == 4) begin chk("hold_ovf_setwins", ovf, 1); chk("hold_pend_sat", pending, 3); end
      if (out && !prev_out) starts.push_back(i);
      prev_out = out;
    end
    chk("hold_npulses", starts.size(), 4);
    if (starts.size() == 4) begin
      chk("hold_start1", starts[1], 6); chk("hold_start3", starts[3], 18);
    end
    chk("ovf_sticky", ovf, 1);
    tick(0, 1);
    chk("ovf_clr", ovf, 0);

    // Pending=1 and a strobe exactly at end of gap.
    tick(1, 0); tick(1, 0);
    chk("eog_pend1", pending, 1);
    repeat (4) tick(0, 0);
    tick(1, 0);
    chk("eog_out", out, 1); chk("eog_pend_kept", pending, 1);
    repeat (5) tick(0, 0);
    tick(0, 0);
    chk("eog_next_out", out, 1); chk("eog_next_pend", pending, 0);
    repeat (12) tick(0, 0);
    chk("eog_idle", busy, 0);

    // Async reset mid-HIGH with pending and ovf set.
    for (int i = 0; i < 5; i++) tick(1, 0);
    repeat (3) tick(0, 0);
    chk("pre_rst_out", out, 1); chk("pre_rst_ovf", ovf, 1);
    #2 rst = 1; model_reset();
    #1;
    chk("arst_out", out, 0); chk("arst_busy", busy, 0);
    chk("arst_pend", pending, 0); chk("arst_ovf", ovf, 0);
    @(negedge clk); rst = 0;
    tick(1, 0);
    chk("post_rst_out", out, 1); chk("post_rst_busy", busy, 1);
    chk("post_rst_pend", pending, 0);
    repeat (10) tick(0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
      chk("rnd_out", out, m_out());
      chk("rnd_busy", busy, m_busy());
      chk("rnd_pend", pending, pend);
      chk("rnd_ovf", ovf, movf);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
